// File: rtl/wave_mixer.sv
// wave_mixer: N-voice audio mixer between the waveform generators and i2s_ctrl.
// Gathers one sample per channel, applies enable and Q1.(G-1) gain through a
// time-multiplexed MAC, saturates to width_p and hands the result downstream.
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   data_i/valid_i/ready_o   per-channel sample input handshake
//   enable_i, gain_i         per-channel mute and unsigned gain
//   data_o/valid_o/ready_i   mixed sample output handshake
//   clip_o                   sticky saturation flag
//   clip_count_o             clamped-frame counter (WAVE_MIXER_CLIP_COUNT_EN), else 0
module wave_mixer #(
    parameter int width_p        = 16,
    parameter int num_channels_p = 4,
    parameter int gain_width_p   = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [num_channels_p*width_p-1:0]      data_i,
    input  logic [num_channels_p-1:0]              valid_i,
    output logic [num_channels_p-1:0]              ready_o,
    input  logic [num_channels_p-1:0]              enable_i,
    input  logic [num_channels_p*gain_width_p-1:0] gain_i,
    output logic [width_p-1:0]                     data_o,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic                                   clip_o,
    output logic [15:0]                            clip_count_o
);

    localparam int N  = num_channels_p;
    localparam int W  = width_p;
    localparam int G  = gain_width_p;
    localparam int AW = W + G + $clog2(N) + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    localparam logic signed [AW-1:0] SMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATHER,
        S_MAC,
        S_SAT,
        S_OUT
    } state_t;

    state_t                r_state;
    logic [N-1:0]          r_done;
    logic signed [W-1:0]   r_samp [N];
    logic signed [AW-1:0]  r_acc;
    logic [IW-1:0]         r_idx;

    logic [G-1:0]          w_gain [N];
    logic [N-1:0]          w_cap;
    logic [N-1:0]          w_done_next;
    logic signed [W+G:0]   w_prod;
    logic signed [AW-1:0]  w_term;
    logic signed [AW-1:0]  w_shift;
    logic                  w_hi;
    logic                  w_lo;
    logic [W-1:0]          w_res;

    for (genvar k = 0; k < N; k++) begin : g_gain
        assign w_gain[k] = gain_i[k*G +: G];
    end

    // Disabled channels stay ready but never latch a sample.
    assign ready_o     = (r_state == S_GATHER) ? ~r_done : '0;
    assign w_cap       = valid_i & ready_o & enable_i;
    assign w_done_next = r_done | w_cap | ~enable_i;

    // Gain is unsigned: widen with a zero MSB before the signed multiply.
    assign w_prod  = r_samp[r_idx] * $signed({1'b0, w_gain[r_idx]});
    assign w_term  = enable_i[r_idx] ? AW'(w_prod) : '0;

    assign w_shift = r_acc >>> (G - 1);
    assign w_hi    = w_shift > SMAX;
    assign w_lo    = w_shift < SMIN;
    assign w_res   = w_hi ? SMAX[W-1:0] :
                     w_lo ? SMIN[W-1:0] : w_shift[W-1:0];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_done  <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            clip_o  <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_samp[k] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_state <= S_GATHER;
                end
                S_GATHER: begin
                    for (int k = 0; k < N; k++) begin
                        if (w_cap[k]) begin
                            r_samp[k] <= data_i[k*W +: W];
                        end
                    end
                    r_done <= r_done | w_cap;
                    if (&w_done_next) begin
                        r_idx   <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_term;
                    if (r_idx == LAST) begin
                        r_state <= S_SAT;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                // Extra stage so the saturated result is registered
                // from a settled accumulator.
                S_SAT: begin
                    data_o  <= w_res;
                    valid_o <= 1'b1;
                    if (w_hi || w_lo) begin
                        clip_o <= 1'b1;
                    end
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        r_done  <= '0;
                        r_acc   <= '0;
                        r_state <= S_GATHER;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef WAVE_MIXER_CLIP_COUNT_EN
    logic        r_clamped;
    logic [15:0] r_clip_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_clamped  <= 1'b0;
            r_clip_cnt <= '0;
        end else begin
            if (r_state == S_SAT) begin
                r_clamped <= w_hi | w_lo;
            end
            if (r_state == S_OUT && ready_i && r_clamped &&
                r_clip_cnt != 16'hFFFF) begin
                r_clip_cnt <= r_clip_cnt + 16'd1;
            end
        end
    end

    assign clip_count_o = r_clip_cnt;
`else
    assign clip_count_o = '0;
`endif

endmodule

// File: tb/tb_wave_mixer.sv
// Self-checking bench for wave_mixer (4 channels, 16-bit samples, 8-bit gain).
// Directed frames push expected results; a negedge monitor checks handshakes.
module tb_wave_mixer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] data_i;
    logic [3:0]  valid_i;
    logic [3:0]  ready_o;
    logic [3:0]  enable_i;
    logic [31:0] gain_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        clip_o;
    logic [15:0] clip_count_o;

    typedef struct {
        logic [15:0] d;
        logic        c;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    wave_mixer #(
        .width_p(16),
        .num_channels_p(4),
        .gain_width_p(8)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .data_i(data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .enable_i(enable_i),
        .gain_i(gain_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .clip_o(clip_o),
        .clip_count_o(clip_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input int d, input logic c);
        exp_t e;
        e.d = 16'(d);
        e.c = c;
        q.push_back(e);
    endtask

    task automatic wait_gather();
        int n;
        n = 0;
        while (!(ready_o == 4'hF && !valid_o) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            chk("gather_timeout", 32'(n), 32'd0);
        end
    endtask

    task automatic present(input int s0, input int s1, input int s2,
                           input int s3, input logic [3:0] vld);
        data_i  = {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
        valid_i = vld;
        tick();
        valid_i = '0;
    endtask

    task automatic measure(output int lat);
        lat = 0;
        while (!valid_o && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Monitor: a handshake completes at the next rising edge.
    always @(negedge clk_i) begin
        if (!reset_i && valid_o && ready_i) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 32'(data_o), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data_o", 32'(data_o), 32'(e.d));
                chk("clip_o", 32'(clip_o), 32'(e.c));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] held;
        logic        stable;
        int          n;
        logic [15:0] exp_cnt;

        reset_i  = 1'b1;
        data_i   = '0;
        valid_i  = '0;
        enable_i = 4'hF;
        gain_i   = {8'd128, 8'd128, 8'd128, 8'd128};
        ready_i  = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_clip", 32'(clip_o), 32'd0);
        chk("rst_count", 32'(clip_count_o), 32'd0);
        reset_i = 1'b0;
        tick();
        chk("gather_ready", 32'(ready_o), 32'hF);

        // Plain sum and latency
        wait_gather();
        push(2500, 1'b0);
        present(1000, 2000, -500, 0, 4'hF);
        chk("mac_ready_low", 32'(ready_o), 32'd0);
        measure(lat);
        chk("latency_sum", 32'(lat), 32'd5);

        // Saturation both ways
        wait_gather();
        push(32767, 1'b1);
        present(30000, 30000, 30000, 30000, 4'hF);
        wait_gather();
        push(-32768, 1'b1);
        present(-30000, -30000, -30000, -30000, 4'hF);
        wait_gather();
        chk("count_after_sat_nomacro_or_2",
            32'(clip_count_o),
`ifdef WAVE_MIXER_CLIP_COUNT_EN
            32'd2
`else
            32'd0
`endif
        );

        // Half gain on ch0, other channels muted and idle
        enable_i = 4'b0001;
        gain_i   = {8'd128, 8'd128, 8'd128, 8'd64};
        wait_gather();
        chk("mute_ready_hi", 32'(ready_o[3:1]), 32'h7);
        push(500, 1'b1);
        present(1000, 0, 0, 0, 4'b0001);
        measure(lat);
        chk("latency_mute", 32'(lat), 32'd5);

        // All channels disabled
        enable_i = 4'b0000;
        wait_gather();
        push(0, 1'b1);
        present(7, 7, 7, 7, 4'b0000);
        measure(lat);
        chk("latency_all_off", 32'(lat), 32'd5);

        // Backpressure with a negative result that rounds toward -inf
        enable_i = 4'hF;
        wait_gather();
        ready_i = 1'b0;
        push(-2, 1'b1);
        present(-3, 0, 0, 0, 4'hF);
        measure(lat);
        chk("bp_valid", 32'(valid_o), 32'd1);
        held   = data_o;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!valid_o || data_o !== held || ready_o !== 4'h0) begin
                stable = 1'b0;
            end
        end
        chk("bp_stable", 32'(stable), 32'd1);
        ready_i = 1'b1;
        tick();
        tick();
        chk("bp_release", 32'(valid_o), 32'd0);
        gain_i = {8'd128, 8'd128, 8'd128, 8'd128};

        // Reset during the second MAC cycle
        wait_gather();
        present(500, 500, 500, 500, 4'hF);
        tick();
        reset_i = 1'b1;
        tick();
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_clip", 32'(clip_o), 32'd0);
        chk("midrst_ready", 32'(ready_o), 32'd0);
        reset_i = 1'b0;
        tick();
        chk("midrst_ready_f", 32'(ready_o), 32'hF);
        push(400, 1'b0);
        present(100, 100, 100, 100, 4'hF);
        chk("post_rst_count", 32'(clip_count_o), 32'd0);

        // Clip counter: three clamped frames then one clean frame
        for (int f = 0; f < 3; f++) begin
            wait_gather();
            push(32767, 1'b1);
            present(30000, 30000, 30000, 30000, 4'hF);
        end
        wait_gather();
        push(100, 1'b1);
        present(10, 20, 30, 40, 4'hF);
        wait_gather();
`ifdef WAVE_MIXER_CLIP_COUNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        chk("clip_count", 32'(clip_count_o), 32'(exp_cnt));

        n = 0;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
